// File: rtl/pipe_fd_skid.sv
// Fetch/decode pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Flush injects bubbles; STALL_CNT saturates on cycles where decode holds off a valid entry.
module pipe_fd_skid #(
  parameter int unsigned                INSTR_WIDTH = 32,
  parameter int unsigned                PC_WIDTH    = 32,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = '1,
  parameter logic [PC_WIDTH-1:0]        PC_RST      = '0,
  parameter int unsigned                CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   VALID_F,
  output logic                   READY_F,
  input  logic [INSTR_WIDTH-1:0] INSTR_F,
  input  logic [PC_WIDTH-1:0]    PCPLUS4_F,
  input  logic                   FLUSH,
  output logic                   VALID_D,
  input  logic                   READY_D,
  output logic [INSTR_WIDTH-1:0] INSTR_D,
  output logic [PC_WIDTH-1:0]    PCPLUS4_D,
  output logic [1:0]             OCCUPANCY,
  output logic [CNT_WIDTH-1:0]   STALL_CNT
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] out_instr, skd_instr;
  logic [PC_WIDTH-1:0]    out_pc, skd_pc;
  logic [CNT_WIDTH-1:0]   stall_cnt;
  logic                   push, pop, stall;

  // Handshake flags come only from registered state, so no input-to-output paths.
  assign VALID_D   = (state != S_EMPTY);
  assign READY_F   = (state != S_TWO);
  assign OCCUPANCY = state;
  assign INSTR_D   = VALID_D ? out_instr : NOP_INSTR;
  assign PCPLUS4_D = VALID_D ? out_pc    : PC_RST;
  assign STALL_CNT = stall_cnt;

  assign push  = VALID_F & READY_F;
  assign pop   = VALID_D & READY_D;
  assign stall = VALID_D & ~READY_D;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= S_EMPTY;
      out_instr <= NOP_INSTR;
      out_pc    <= PC_RST;
      skd_instr <= NOP_INSTR;
      skd_pc    <= PC_RST;
      stall_cnt <= '0;
    end else if (FLUSH) begin
      state     <= S_EMPTY;
      out_instr <= NOP_INSTR;
      out_pc    <= PC_RST;
      skd_instr <= NOP_INSTR;
      skd_pc    <= PC_RST;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      case (state)
        S_EMPTY: begin
          if (push) begin
            state     <= S_ONE;
            out_instr <= INSTR_F;
            out_pc    <= PCPLUS4_F;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            out_instr <= INSTR_F;
            out_pc    <= PCPLUS4_F;
          end else if (push) begin
            state     <= S_TWO;
            skd_instr <= INSTR_F;
            skd_pc    <= PCPLUS4_F;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state     <= S_ONE;
            out_instr <= skd_instr;
            out_pc    <= skd_pc;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fd_skid.sv
// Directed bench for pipe_fd_skid: per-cycle vector table plus saturation and CLR+FLUSH sequences.
module tb_pipe_fd_skid;

  localparam logic [31:0] NOP = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        CLR, VALID_F, READY_F, FLUSH, VALID_D, READY_D;
  logic [31:0] INSTR_F, PCPLUS4_F, INSTR_D, PCPLUS4_D;
  logic [1:0]  OCCUPANCY;
  logic [3:0]  STALL_CNT;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_fd_skid #(.CNT_WIDTH(4)) dut (
    .CLK(CLK), .CLR(CLR), .VALID_F(VALID_F), .READY_F(READY_F),
    .INSTR_F(INSTR_F), .PCPLUS4_F(PCPLUS4_F), .FLUSH(FLUSH),
    .VALID_D(VALID_D), .READY_D(READY_D), .INSTR_D(INSTR_D),
    .PCPLUS4_D(PCPLUS4_D), .OCCUPANCY(OCCUPANCY), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v, fl, clr, rd;
    logic [31:0] instr, pc;
    logic        e_vd, e_rf;
    logic [31:0] e_instr, e_pc;
    logic [1:0]  e_occ;
    logic [3:0]  e_st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                     input logic fl, input logic clr, input logic rd,
                     input logic e_vd, input logic e_rf, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic [1:0] e_occ, input logic [3:0] e_st);
    vec_t t;
    t.v = v; t.instr = instr; t.pc = pc; t.fl = fl; t.clr = clr; t.rd = rd;
    t.e_vd = e_vd; t.e_rf = e_rf; t.e_instr = e_instr; t.e_pc = e_pc;
    t.e_occ = e_occ; t.e_st = e_st;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic fl, input logic clr, input logic rd);
    VALID_F = v; INSTR_F = instr; PCPLUS4_F = pc; FLUSH = fl; CLR = clr; READY_D = rd;
  endtask

  // Apply one cycle of inputs, then check all outputs just after the edge.
  task automatic cycle_chk(input int unsigned idx, input vec_t t);
    drive(t.v, t.instr, t.pc, t.fl, t.clr, t.rd);
    @(posedge CLK); #1;
    chk("valid_d",   idx, {31'd0, VALID_D}, {31'd0, t.e_vd});
    chk("ready_f",   idx, {31'd0, READY_F}, {31'd0, t.e_rf});
    chk("instr_d",   idx, INSTR_D,          t.e_instr);
    chk("pcplus4_d", idx, PCPLUS4_D,        t.e_pc);
    chk("occupancy", idx, {30'd0, OCCUPANCY}, {30'd0, t.e_occ});
    chk("stall_cnt", idx, {28'd0, STALL_CNT}, {28'd0, t.e_st});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    drive(1'b1, 32'hDEAD, 32'h99, 1'b0, 1'b1, 1'b0);

    //   v  instr         pc      fl   clr  rd    vd rf  e_instr        e_pc   occ st
    // reset with VALID_F high: nothing captured
    add(1, 32'hDEAD,      32'h99, 0,   1,   0,    0, 1,  NOP,           0,     0,  0);
    add(1, 32'hDEAD,      32'h99, 0,   1,   0,    0, 1,  NOP,           0,     0,  0);
    // streaming
    add(1, 32'h00000013,  4,      0,   0,   1,    1, 1,  32'h00000013,  4,     1,  0);
    add(1, 32'h00500093,  8,      0,   0,   1,    1, 1,  32'h00500093,  8,     1,  0);
    add(1, 32'h00A00113,  12,     0,   0,   1,    1, 1,  32'h00A00113,  12,    1,  0);
    add(0, 0,             0,      0,   0,   1,    0, 1,  NOP,           0,     0,  0);
    // back-pressure, skid fill, drain in order
    add(1, 32'h11,        4,      0,   0,   0,    1, 1,  32'h11,        4,     1,  0);
    add(1, 32'h22,        8,      0,   0,   0,    1, 0,  32'h11,        4,     2,  1);
    add(1, 32'h33,        12,     0,   0,   0,    1, 0,  32'h11,        4,     2,  2);
    add(1, 32'h33,        12,     0,   0,   0,    1, 0,  32'h11,        4,     2,  3);
    add(1, 32'h33,        12,     0,   0,   0,    1, 0,  32'h11,        4,     2,  4);
    add(1, 32'h33,        12,     0,   0,   1,    1, 1,  32'h22,        8,     1,  4);
    add(1, 32'h33,        12,     0,   0,   1,    1, 1,  32'h33,        12,    1,  4);
    add(0, 0,             0,      0,   0,   1,    0, 1,  NOP,           0,     0,  4);
    // flush in TWO with an incoming entry
    add(1, 32'h66,        24,     0,   0,   0,    1, 1,  32'h66,        24,    1,  4);
    add(1, 32'h77,        28,     0,   0,   0,    1, 0,  32'h66,        24,    2,  5);
    add(1, 32'h44,        16,     1,   0,   0,    0, 1,  NOP,           0,     0,  5);
    add(0, 0,             0,      0,   0,   1,    0, 1,  NOP,           0,     0,  5);
    // flush in ONE with simultaneous push and pop
    add(1, 32'h88,        32,     0,   0,   1,    1, 1,  32'h88,        32,    1,  5);
    add(1, 32'h99,        36,     1,   0,   1,    0, 1,  NOP,           0,     0,  5);

    foreach (vq[i]) cycle_chk(i, vq[i]);

    // Saturation: one held entry, decode stalled for 20 cycles.
    drive(0, 0, 0, 0, 1, 0);
    @(posedge CLK); #1;
    drive(1, 32'hABC, 40, 0, 0, 0);
    @(posedge CLK); #1;
    chk("sat_load_occ", 0, {30'd0, OCCUPANCY}, 32'd1);
    chk("sat_load_cnt", 0, {28'd0, STALL_CNT}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      chk("sat_cnt", k, {28'd0, STALL_CNT}, (k < 15) ? k : 15);
    end
    chk("sat_instr", 0, INSTR_D, 32'hABC);
    drive(0, 0, 0, 0, 1, 0);
    @(posedge CLK); #1;
    chk("sat_clr_cnt", 0, {28'd0, STALL_CNT}, 32'd0);
    chk("sat_clr_vd",  0, {31'd0, VALID_D}, 32'd0);

    // CLR together with FLUSH while in TWO and mid-stall.
    drive(1, 32'hA1, 44, 0, 0, 0);
    @(posedge CLK); #1;
    drive(1, 32'hB2, 48, 0, 0, 0);
    @(posedge CLK); #1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) @(posedge CLK);
    #1;
    chk("mid_cnt", 0, {28'd0, STALL_CNT}, 32'd7);
    chk("mid_occ", 0, {30'd0, OCCUPANCY}, 32'd2);
    t = '{v:1, instr:32'hBAD, pc:52, fl:1, clr:1, rd:0,
          e_vd:0, e_rf:1, e_instr:NOP, e_pc:0, e_occ:0, e_st:0};
    cycle_chk(100, t);
    t = '{v:1, instr:32'h55, pc:20, fl:0, clr:0, rd:1,
          e_vd:1, e_rf:1, e_instr:32'h55, e_pc:20, e_occ:1, e_st:0};
    cycle_chk(101, t);
    t = '{v:0, instr:0, pc:0, fl:0, clr:0, rd:1,
          e_vd:0, e_rf:1, e_instr:NOP, e_pc:0, e_occ:0, e_st:0};
    cycle_chk(102, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_fd_skid.md
Name: pipe_fd_skid

Overview:
- Parametrised fetch/decode pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Supports flush with bubble (NOP) injection and provides stall-cycle instrumentation.
- Sits between instruction fetch and decode, replacing a plain clear-only stage register.
- Lets decode back-pressure fetch without dropping or duplicating instructions.

Parameters:
- INSTR_WIDTH, 32, width of instruction word.
- PC_WIDTH, 32, width of PC+4 value.
- NOP_INSTR, {INSTR_WIDTH{1'b1}}, instruction pattern driven while the stage holds no valid entry.
- PC_RST, {PC_WIDTH{1'b0}}, PC+4 value driven while no valid entry.
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- CLR  input  1  reset, synchronous, active-high.
- VALID_F  input  1  fetch presents an entry.
- READY_F  output  1  stage can accept an entry this cycle.
- INSTR_F  input  INSTR_WIDTH  fetched instruction.
- PCPLUS4_F  input  PC_WIDTH  fetched PC+4.
- FLUSH  input  1  discard all held and incoming entries.
- VALID_D  output  1  decode-side entry valid.
- READY_D  input  1  decode accepts the entry.
- INSTR_D  output  INSTR_WIDTH  instruction to decode.
- PCPLUS4_D  output  PC_WIDTH  PC+4 to decode.
- OCCUPANCY  output  2  entries held (0, 1 or 2).
- STALL_CNT  output  CNT_WIDTH  cycles with VALID_D=1 and READY_D=0.

Behaviour:
- Transfer definitions:
  - Upstream transfer (push) = VALID_F & READY_F.
  - Downstream transfer (pop) = VALID_D & READY_D.
- All outputs are registered or decoded directly from registered state. No combinational path from VALID_F/READY_D to READY_F/VALID_D.
- Latency: an entry pushed in cycle N is on INSTR_D/PCPLUS4_D with VALID_D=1 in cycle N+1 if the stage was empty, or if the stage held one entry that was popped in cycle N.
- Storage: output register (OUT) plus skid register (SKD).
- States:
  - EMPTY: OCCUPANCY=0, VALID_D=0, READY_F=1.
  - ONE: OCCUPANCY=1, VALID_D=1, READY_F=1.
  - TWO: OCCUPANCY=2, VALID_D=1, READY_F=0.
- Transitions, when neither FLUSH nor CLR is asserted:
  - EMPTY: push -> ONE, OUT<=input. No push -> stay.
  - ONE: push & pop -> ONE, OUT<=input. Push only -> TWO, SKD<=input. Pop only -> EMPTY. Neither -> stay, OUT held.
  - TWO: pop -> ONE, OUT<=SKD. No pop -> stay. VALID_F is ignored because READY_F=0.
- Ordering: strict FIFO. No loss, no duplication.
- Output values when VALID_D=0: INSTR_D=NOP_INSTR, PCPLUS4_D=PC_RST.
- Output values when VALID_D=1: INSTR_D/PCPLUS4_D = OUT contents, held stable until popped.
- FLUSH (priority over push/pop):
  - Next state EMPTY; OUT and SKD loaded with NOP_INSTR/PC_RST.
  - Any same-cycle push is discarded.
  - A same-cycle pop is still considered consumed by decode.
  - STALL_CNT is not cleared by FLUSH.
- CLR (highest priority, synchronous):
  - Same effect as FLUSH, and additionally STALL_CNT<=0.
  - Takes effect at the rising edge where CLR=1, regardless of state, including mid-stall in TWO.
- Reset values of outputs:
  - VALID_D=0, READY_F=1, OCCUPANCY=0, STALL_CNT=0.
  - INSTR_D=NOP_INSTR, PCPLUS4_D=PC_RST.
- STALL_CNT:
  - Increments by 1 on each edge where VALID_D=1 & READY_D=0 and neither CLR nor FLUSH is asserted.
  - Saturates at 2^CNT_WIDTH-1, with no wrap.
- Simultaneous FLUSH and CLR: CLR behaviour.

Test Plan:
- Reset: CLR=1 for 2 cycles, VALID_F=1 -> VALID_D=0, INSTR_D=32'hFFFFFFFF, PCPLUS4_D=0, READY_F=1, OCCUPANCY=0, STALL_CNT=0. No entry captured.
- Streaming: READY_D=1, push (0x00000013,4), (0x00500093,8), (0x00A00113,12) on consecutive cycles -> each appears on INSTR_D/PCPLUS4_D one cycle later, one per cycle. READY_F stays 1, OCCUPANCY=1 throughout.
- Back-pressure: READY_D=0, push A=(0x11,4), B=(0x22,8), hold C=(0x33,12) at VALID_F:
  - After 2 pushes: OCCUPANCY=2, READY_F=0, INSTR_D=0x11.
  - Hold 3 cycles -> STALL_CNT=4.
  - Raise READY_D -> outputs 0x11, 0x22, 0x33 in order, no duplicates.
- Flush in TWO with VALID_F=1 (0x44,16) -> next cycle VALID_D=0, INSTR_D=NOP_INSTR, OCCUPANCY=0, READY_F=1. 0x44 never appears. STALL_CNT unchanged.
- Saturation: CNT_WIDTH=4, one entry held, READY_D=0 for 20 cycles -> STALL_CNT=15 and stays 15. Subsequent CLR -> 0.
- CLR mid-operation: in TWO with STALL_CNT=7, assert CLR together with FLUSH for 1 cycle -> next cycle all reset values.
  - Following push (0x55,20) with READY_D=1 appears one cycle later.
